seq_pattern_detector: RTL and testbench
=======================================

Name: seq_pattern_detector

Overview:
- Parametrised serial bit-pattern detector; successor to the fixed 4-bit "1011" Moore/Mealy detector.
- Pattern, pattern length, output mode (Moore/Mealy) and overlap mode are all elaboration-time parameters.
- Adds an input-qualify enable, a saturating match counter and a visible progress state.
- Sits on a one-bit serial data stream in the `clock` domain; feeds a control FSM or status register.

Parameters:
- PAT_LEN, 4: pattern length in bits. Legal range 2..16; elaboration error outside this range.
- PATTERN, 4'b1011: pattern, PAT_LEN bits wide. PATTERN[PAT_LEN-1] is the first bit received.
- MEALY, 0: 0 gives a registered Moore output; 1 gives a combinational Mealy output.
- OVERLAP, 1: 1 lets a match's suffix start the next match; 0 restarts from empty after every match.
- CNT_W, 8: width of match_count.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  sequence_in is sampled only on edges where enable=1.
- sequence_in  in  1  serial data bit.
- count_clr  in  1  synchronous clear of match_count.
- detector_out  out  1  match indication (timing per MEALY).
- match_count  out  CNT_W  saturating count of matches.
- match_state  out  $clog2(PAT_LEN+1)  current progress k (matched-prefix length).

Behaviour:
- State k (0..PAT_LEN-1) = length of the longest pattern prefix that is a suffix of the accepted bits. Moore mode adds a terminal state k=PAT_LEN.
- Transition delta(k,b):
  - If b == PATTERN[PAT_LEN-1-k], go to k+1.
  - Otherwise use the KMP fallback: the longest border j<k of the prefix such that the prefix of length j followed by b is a pattern prefix; go to j+1 if found, else 0.
  - The fallback table is computed at elaboration by a constant function. No runtime search.
- Match event: the edge where k=PAT_LEN-1, enable=1 and the bit matches.
- Post-match state:
  - OVERLAP=1: B = border length of the full pattern (example: B=1 for 1011).
  - OVERLAP=0: 0.
- Moore (MEALY=0):
  - A match event enters state PAT_LEN.
  - detector_out = (state==PAT_LEN); it is high for exactly the one cycle after the completing edge.
  - From PAT_LEN with enable=1: next = delta(B,b) for OVERLAP=1, delta(0,b) for OVERLAP=0.
  - From PAT_LEN with enable=0: state holds and detector_out stays high until the next enabled bit.
- Mealy (MEALY=1):
  - detector_out = enable & (k==PAT_LEN-1) & (sequence_in==PATTERN[0]), combinational in the cycle before the completing edge.
  - The completing edge moves the state to the post-match state.
- enable=0: state holds, no match event, no count.
- match_count:
  - +1 on each match event; saturates at 2^CNT_W-1.
  - count_clr has priority over an increment in the same cycle; result is 0.
- reset (synchronous, dominant over everything):
  - state=0, match_count=0, detector_out=0 (Moore register cleared; Mealy output low because state=0 and PAT_LEN≥2).
  - A reset mid-pattern discards partial progress; the first post-reset bit is evaluated from state 0.
- No X propagation: unused state encodings return to 0 on the next edge.

Decomposition:
- Shared package seq_det_pkg holds:
  - the constant function computing the KMP fallback/next-state table;
  - the state-width helper $clog2(PAT_LEN+1);
  - mode constants MODE_MOORE=0, MODE_MEALY=1.
- One sub-module, sat_counter (CNT_W, inc, clr, saturating). The FSM stays in seq_pattern_detector.

Test Plan:
- Moore, overlap, 1011, enable=1; hold reset 3 cycles, then stream 1,0,1,1,0,1,1 → detector_out high exactly in the cycles after bits 4 and 7; match_count=2; match_state after bit 4 = 4.
- Moore, OVERLAP=0, same stream → a single pulse after bit 4, none after bit 7; match_count=1.
- MEALY=1, overlap, stream 1,0,1,1 → detector_out high during the bit-4 cycle (before its edge), low afterwards; match_count becomes 1 at that edge.
- Toggle enable=0 for 3 cycles between bits 2 and 3 of 1011 → match still detected after bit 4; no pulse or count during the gap; match_state stays at 2 through the gap.
- PAT_LEN=6, PATTERN=6'b110110, overlap, stream 110110110 → two matches (bits 6 and 9), since border B=3. Assert reset after bit 8 instead → no second match; state 0; count 0.
- CNT_W=2, five matches → match_count saturates at 3. count_clr together with a match event → match_count=0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: mode constants, state-width helper and elaboration-time KMP transition table for seq_pattern_detector
package seq_det_pkg;
   localparam int MODE_MOORE = 0;
   localparam int MODE_MEALY = 1;
   localparam int MAX_LEN = 16;
   localparam int ENT_W = 5;
   localparam int TBL_W = 2 * MAX_LEN * ENT_W;
   function automatic int state_w(input int len);
      return $clog2(len + 1);
   endfunction
   function automatic int delta(input logic [MAX_LEN-1:0] pat, input int len, input int k, input logic b);
      int r = 0;
      logic ok;
      for (int m = 1; m <= k + 1; m++) begin
         ok = 1'b1;
         for (int t = 0; t < m; t++)
            if (((k + 1 - m + t) < k ? pat[len - 2 - k + m - t] : b) != pat[len - 1 - t]) ok = 1'b0;
         if (ok) r = m;
      end
      return r;
   endfunction
   function automatic int border_len(input logic [MAX_LEN-1:0] pat, input int len);
      int r = 0;
      logic ok;
      for (int m = 1; m < len; m++) begin
         ok = 1'b1;
         for (int t = 0; t < m; t++)
            if (pat[m - 1 - t] != pat[len - 1 - t]) ok = 1'b0;
         if (ok) r = m;
      end
      return r;
   endfunction
   function automatic logic [TBL_W-1:0] build_table(input logic [MAX_LEN-1:0] pat, input int len);
      logic [TBL_W-1:0] t = '0;
      for (int k = 0; k < len; k++)
         for (int b = 0; b < 2; b++)
            t[(2 * k + b) * ENT_W +: ENT_W] = ENT_W'(delta(pat, len, k, b[0]));
      return t;
   endfunction
endpackage

// File: rtl/seq_pattern_detector_sat_counter.sv
// sat_counter: saturating up-counter; ports clock, reset, inc (count up), clr (clear, beats inc), count
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);
   always_ff @(posedge clock)
      if (reset || clr) count <= '0;
      else if (inc && count != '1) count <= count + W'(1);
endmodule

// File: rtl/seq_pattern_detector.sv
// seq_pattern_detector: parametrised serial pattern detector; ports clock, reset, enable, sequence_in, count_clr -> detector_out, match_count, match_state
module seq_pattern_detector
   import seq_det_pkg::*;
#(
   parameter int               PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
   parameter int               MEALY   = MODE_MOORE,
   parameter int               OVERLAP = 1,
   parameter int               CNT_W   = 8
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          enable,
   input  logic                          sequence_in,
   input  logic                          count_clr,
   output logic                          detector_out,
   output logic [CNT_W-1:0]              match_count,
   output logic [state_w(PAT_LEN)-1:0]   match_state
);
   localparam int SW = state_w(PAT_LEN);
   localparam logic [TBL_W-1:0] TBL = build_table(MAX_LEN'(PATTERN), PAT_LEN);
   localparam int B = border_len(MAX_LEN'(PATTERN), PAT_LEN);
   localparam logic [SW-1:0] LAST = SW'(PAT_LEN);
   localparam logic [SW-1:0] POST = OVERLAP != 0 ? SW'(B) : '0;
   if (PAT_LEN < 2 || PAT_LEN > MAX_LEN) begin : g_bad_len
      $error("seq_pattern_detector: PAT_LEN must be in 2..16");
   end
   logic [SW-1:0] state, eff, state_d;
   logic [ENT_W-1:0] nxt;
   logic [8:0] idx;
   logic valid, hit;
   // The Moore terminal state behaves like the post-match state for the next bit.
   always_comb begin
      valid = MEALY == MODE_MEALY ? state < LAST : state <= LAST;
      eff = !valid ? '0 : state == LAST ? POST : state;
      idx = 9'({eff, sequence_in}) * 9'(ENT_W);
      nxt = TBL[idx +: ENT_W];
      hit = enable && nxt == ENT_W'(PAT_LEN);
      state_d = !valid ? '0 : !enable ? state : hit ? (MEALY == MODE_MEALY ? POST : LAST) : nxt[SW-1:0];
   end
   always_ff @(posedge clock) state <= reset ? '0 : state_d;
   assign match_state = state;
   assign detector_out = MEALY == MODE_MEALY ? hit : state == LAST;
   sat_counter #(.W(CNT_W)) u_cnt (
      .clock(clock),
      .reset(reset),
      .inc(hit),
      .clr(count_clr),
      .count(match_count)
   );
endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb_seq_pattern_detector: scoreboard bench over five detector configurations sharing one input stream
module tb_seq_pattern_detector;
   logic clock = 1'b0, reset = 1'b1, enable = 1'b0, sequence_in = 1'b0, count_clr = 1'b0;
   wire [4:0] det_w;
   wire [4:0][7:0] cnt_w;
   wire [4:0][2:0] st_w;
   always #5 clock = ~clock;
   assign cnt_w[4][7:2] = '0;
   seq_pattern_detector u0 (.clock(clock), .reset(reset), .enable(enable), .sequence_in(sequence_in), .count_clr(count_clr),
      .detector_out(det_w[0]), .match_count(cnt_w[0]), .match_state(st_w[0]));
   seq_pattern_detector #(.OVERLAP(0)) u1 (.clock(clock), .reset(reset), .enable(enable), .sequence_in(sequence_in), .count_clr(count_clr),
      .detector_out(det_w[1]), .match_count(cnt_w[1]), .match_state(st_w[1]));
   seq_pattern_detector #(.MEALY(1)) u2 (.clock(clock), .reset(reset), .enable(enable), .sequence_in(sequence_in), .count_clr(count_clr),
      .detector_out(det_w[2]), .match_count(cnt_w[2]), .match_state(st_w[2]));
   seq_pattern_detector #(.PAT_LEN(6), .PATTERN(6'b110110)) u3 (.clock(clock), .reset(reset), .enable(enable), .sequence_in(sequence_in), .count_clr(count_clr),
      .detector_out(det_w[3]), .match_count(cnt_w[3]), .match_state(st_w[3]));
   seq_pattern_detector #(.CNT_W(2)) u4 (.clock(clock), .reset(reset), .enable(enable), .sequence_in(sequence_in), .count_clr(count_clr),
      .detector_out(det_w[4]), .match_count(cnt_w[4][1:0]), .match_state(st_w[4]));

   typedef struct packed { logic rst, en, b, clr; } stim_t;
   typedef struct packed { logic mealy; logic [4:0] det; logic [4:0][7:0] cnt; logic [4:0][2:0] st; } exp_t;
   localparam stim_t RST = 4'b1000;
   exp_t exp_q[$];
   int compared = 0, mismatched = 0;
   int len_m [5] = '{4, 4, 4, 6, 4};
   logic [15:0] pat_m [5] = '{16'hb, 16'hb, 16'hb, 16'h36, 16'hb};
   bit ovl_m [5] = '{1, 0, 1, 1, 1};
   int cmax_m [5] = '{255, 255, 255, 255, 3};
   logic [15:0] h_m [5];
   int hn_m [5], cnt_m [5];
   bit mo_m [5];

   // longest pattern prefix (up to maxk bits) equal to the newest bits of the history
   function automatic int lp(logic [15:0] h, int hn, logic [15:0] p, int len, int maxk);
      int r = 0;
      logic [31:0] mk;
      for (int m = 1; m <= maxk; m++) begin
         mk = (32'h1 << m) - 32'h1;
         if (m <= hn && (({16'h0, h} & mk) == ((32'(p) >> (len - m)) & mk))) r = m;
      end
      return r;
   endfunction

   function automatic stim_t bitv(logic b, logic en = 1'b1, logic clr = 1'b0);
      return {1'b0, en, b, clr};
   endfunction

   task automatic drive(input stim_t s);
      exp_t e;
      logic [15:0] h2;
      int n2;
      bit m;
      @(negedge clock);
      reset = s.rst; enable = s.en; sequence_in = s.b; count_clr = s.clr;
      e = '0;
      for (int i = 0; i < 5; i++) begin
         h2 = {h_m[i][14:0], s.b};
         n2 = hn_m[i] < 16 ? hn_m[i] + 1 : 16;
         m = lp(h2, n2, pat_m[i], len_m[i], len_m[i]) == len_m[i];
         if (i == 2) e.mealy = s.en && m;
         if (s.rst) begin
            h_m[i] = '0; hn_m[i] = 0; cnt_m[i] = 0; mo_m[i] = 1'b0;
         end else begin
            if (s.en) begin
               h_m[i] = h2; hn_m[i] = n2; mo_m[i] = m;
               if (m) begin
                  if (cnt_m[i] < cmax_m[i]) cnt_m[i]++;
                  if (!ovl_m[i]) hn_m[i] = 0;
               end
            end
            if (s.clr) cnt_m[i] = 0;
         end
         e.det[i] = mo_m[i];
         e.cnt[i] = 8'(cnt_m[i]);
         e.st[i] = 3'((i != 2 && mo_m[i]) ? len_m[i] : lp(h_m[i], hn_m[i], pat_m[i], len_m[i], len_m[i] - 1));
      end
      exp_q.push_back(e);
   endtask

   task automatic test_reset;
      exp_t e;
      for (int k = 0; k < 3; k++) begin
         drive(RST);
         e = exp_q.pop_front();
         @(posedge clock); #1;
         for (int i = 0; i < 5; i++) begin
            compared += 3;
            if (det_w[i] !== 1'b0 || det_w[i] !== e.det[i]) begin mismatched++; $display("FAIL reset u%0d det got %0b want 0", i, det_w[i]); end
            if (cnt_w[i] !== e.cnt[i]) begin mismatched++; $display("FAIL reset u%0d count got %0d want %0d", i, cnt_w[i], e.cnt[i]); end
            if (st_w[i] !== e.st[i]) begin mismatched++; $display("FAIL reset u%0d state got %0d want %0d", i, st_w[i], e.st[i]); end
         end
      end
   endtask

   task automatic test_stream;
      stim_t s[$];
      exp_t e;
      logic [6:0] v = 7'b1011011;
      s.push_back(RST);
      for (int k = 6; k >= 0; k--) s.push_back(bitv(v[k]));
      foreach (s[k]) begin
         drive(s[k]);
         e = exp_q.pop_front();
         #1; compared++;
         if (det_w[2] !== e.mealy) begin mismatched++; $display("FAIL stream step %0d mealy det got %0b want %0b", k, det_w[2], e.mealy); end
         @(posedge clock); #1;
         for (int i = 0; i < 5; i++) begin
            if (i != 2) begin compared++; if (det_w[i] !== e.det[i]) begin mismatched++; $display("FAIL stream step %0d u%0d det got %0b want %0b", k, i, det_w[i], e.det[i]); end end
            compared += 2;
            if (cnt_w[i] !== e.cnt[i]) begin mismatched++; $display("FAIL stream step %0d u%0d count got %0d want %0d", k, i, cnt_w[i], e.cnt[i]); end
            if (st_w[i] !== e.st[i]) begin mismatched++; $display("FAIL stream step %0d u%0d state got %0d want %0d", k, i, st_w[i], e.st[i]); end
         end
         if (k == 4) begin compared++; if (st_w[0] !== 3'd4) begin mismatched++; $display("FAIL stream u0 state after bit4 got %0d want 4", st_w[0]); end end
      end
      compared += 3;
      if (cnt_w[0] !== 8'd2) begin mismatched++; $display("FAIL stream u0 final count got %0d want 2", cnt_w[0]); end
      if (cnt_w[1] !== 8'd1) begin mismatched++; $display("FAIL stream u1 final count got %0d want 1", cnt_w[1]); end
      if (cnt_w[2] !== 8'd2) begin mismatched++; $display("FAIL stream u2 final count got %0d want 2", cnt_w[2]); end
   endtask

   task automatic test_enable_gap;
      stim_t s[$];
      exp_t e;
      s.push_back(RST);
      s.push_back(bitv(1)); s.push_back(bitv(0));
      s.push_back(bitv(1, 0)); s.push_back(bitv(1, 0)); s.push_back(bitv(0, 0));
      s.push_back(bitv(1)); s.push_back(bitv(1));
      foreach (s[k]) begin
         drive(s[k]);
         e = exp_q.pop_front();
         #1; compared++;
         if (det_w[2] !== e.mealy) begin mismatched++; $display("FAIL gap step %0d mealy det got %0b want %0b", k, det_w[2], e.mealy); end
         @(posedge clock); #1;
         for (int i = 0; i < 5; i++) begin
            if (i != 2) begin compared++; if (det_w[i] !== e.det[i]) begin mismatched++; $display("FAIL gap step %0d u%0d det got %0b want %0b", k, i, det_w[i], e.det[i]); end end
            compared += 2;
            if (cnt_w[i] !== e.cnt[i]) begin mismatched++; $display("FAIL gap step %0d u%0d count got %0d want %0d", k, i, cnt_w[i], e.cnt[i]); end
            if (st_w[i] !== e.st[i]) begin mismatched++; $display("FAIL gap step %0d u%0d state got %0d want %0d", k, i, st_w[i], e.st[i]); end
         end
         if (k >= 3 && k <= 5) begin compared++; if (st_w[0] !== 3'd2) begin mismatched++; $display("FAIL gap u0 held state got %0d want 2", st_w[0]); end end
      end
      compared++;
      if (cnt_w[0] !== 8'd1 || det_w[0] !== 1'b1) begin mismatched++; $display("FAIL gap u0 result got count %0d det %0b want 1 1", cnt_w[0], det_w[0]); end
   endtask

   task automatic test_len6;
      stim_t s[$];
      exp_t e;
      logic [8:0] v = 9'b110110110;
      s.push_back(RST);
      for (int k = 8; k >= 0; k--) s.push_back(bitv(v[k]));
      s.push_back(RST);
      for (int k = 8; k >= 1; k--) s.push_back(bitv(v[k]));
      s.push_back(RST);
      foreach (s[k]) begin
         drive(s[k]);
         e = exp_q.pop_front();
         #1; compared++;
         if (det_w[2] !== e.mealy) begin mismatched++; $display("FAIL len6 step %0d mealy det got %0b want %0b", k, det_w[2], e.mealy); end
         @(posedge clock); #1;
         for (int i = 0; i < 5; i++) begin
            if (i != 2) begin compared++; if (det_w[i] !== e.det[i]) begin mismatched++; $display("FAIL len6 step %0d u%0d det got %0b want %0b", k, i, det_w[i], e.det[i]); end end
            compared += 2;
            if (cnt_w[i] !== e.cnt[i]) begin mismatched++; $display("FAIL len6 step %0d u%0d count got %0d want %0d", k, i, cnt_w[i], e.cnt[i]); end
            if (st_w[i] !== e.st[i]) begin mismatched++; $display("FAIL len6 step %0d u%0d state got %0d want %0d", k, i, st_w[i], e.st[i]); end
         end
         if (k == 9) begin compared++; if (cnt_w[3] !== 8'd2) begin mismatched++; $display("FAIL len6 u3 two matches got %0d want 2", cnt_w[3]); end end
      end
      compared++;
      if (cnt_w[3] !== 8'd0 || st_w[3] !== 3'd0 || det_w[3] !== 1'b0) begin mismatched++; $display("FAIL len6 u3 after reset got count %0d state %0d det %0b want 0 0 0", cnt_w[3], st_w[3], det_w[3]); end
   endtask

   task automatic test_saturate;
      stim_t s[$];
      exp_t e;
      logic [15:0] v = 16'b1011011011011011;
      s.push_back(RST);
      for (int k = 15; k >= 0; k--) s.push_back(bitv(v[k]));
      s.push_back(bitv(0)); s.push_back(bitv(1)); s.push_back(bitv(1, 1, 1));
      foreach (s[k]) begin
         drive(s[k]);
         e = exp_q.pop_front();
         #1; compared++;
         if (det_w[2] !== e.mealy) begin mismatched++; $display("FAIL sat step %0d mealy det got %0b want %0b", k, det_w[2], e.mealy); end
         @(posedge clock); #1;
         for (int i = 0; i < 5; i++) begin
            if (i != 2) begin compared++; if (det_w[i] !== e.det[i]) begin mismatched++; $display("FAIL sat step %0d u%0d det got %0b want %0b", k, i, det_w[i], e.det[i]); end end
            compared += 2;
            if (cnt_w[i] !== e.cnt[i]) begin mismatched++; $display("FAIL sat step %0d u%0d count got %0d want %0d", k, i, cnt_w[i], e.cnt[i]); end
            if (st_w[i] !== e.st[i]) begin mismatched++; $display("FAIL sat step %0d u%0d state got %0d want %0d", k, i, st_w[i], e.st[i]); end
         end
         if (k == 16) begin
            compared += 2;
            if (cnt_w[4] !== 8'd3) begin mismatched++; $display("FAIL sat u4 saturated count got %0d want 3", cnt_w[4]); end
            if (cnt_w[0] !== 8'd5) begin mismatched++; $display("FAIL sat u0 count got %0d want 5", cnt_w[0]); end
         end
      end
      compared++;
      if (cnt_w[4] !== 8'd0 || cnt_w[0] !== 8'd0 || det_w[0] !== 1'b1) begin mismatched++; $display("FAIL sat clr-vs-match got u4 %0d u0 %0d det %0b want 0 0 1", cnt_w[4], cnt_w[0], det_w[0]); end
   endtask

   task automatic test_random;
      stim_t s[$];
      exp_t e;
      s.push_back(RST);
      for (int k = 0; k < 120; k++)
         s.push_back(k == 60 ? RST : bitv(1'($urandom_range(1)), 1'($urandom_range(9) != 0), 1'($urandom_range(29) == 0)));
      foreach (s[k]) begin
         drive(s[k]);
         e = exp_q.pop_front();
         #1; compared++;
         if (det_w[2] !== e.mealy) begin mismatched++; $display("FAIL random step %0d mealy det got %0b want %0b", k, det_w[2], e.mealy); end
         @(posedge clock); #1;
         for (int i = 0; i < 5; i++) begin
            if (i != 2) begin compared++; if (det_w[i] !== e.det[i]) begin mismatched++; $display("FAIL random step %0d u%0d det got %0b want %0b", k, i, det_w[i], e.det[i]); end end
            compared += 2;
            if (cnt_w[i] !== e.cnt[i]) begin mismatched++; $display("FAIL random step %0d u%0d count got %0d want %0d", k, i, cnt_w[i], e.cnt[i]); end
            if (st_w[i] !== e.st[i]) begin mismatched++; $display("FAIL random step %0d u%0d state got %0d want %0d", k, i, st_w[i], e.st[i]); end
         end
      end
   endtask

   initial begin
      test_reset;
      test_stream;
      test_enable_gap;
      test_len6;
      test_saturate;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
